// File: rtl/block_xfer_pkg.sv
// Shared definitions for block-fill transfers: FSM encoding and block address helpers.
package block_xfer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DELIVER = 2'd3;

    function automatic int unsigned bytes_per_word(input int unsigned wsize);
        return wsize / 8;
    endfunction

    function automatic int unsigned block_offset_bits(input int unsigned wsize,
                                                      input int unsigned words);
        return $clog2(words * wsize / 8);
    endfunction

    // Clears the in-block byte offset; callers truncate back to their address width.
    function automatic logic [63:0] block_align(input logic [63:0] addr,
                                                input int unsigned off_bits);
        return addr & ~((64'd1 << off_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/block_fill_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches from the index after last_i, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_fill_scheduler.sv
// Runs one block fill at a time over a single-word read port and hands the
// assembled block to the round-robin winner.
module block_fill_scheduler
    import block_xfer_pkg::*;
#(
    parameter int WSIZE = 32,
    parameter int WORDS = 4,
    parameter int ASIZE = 32,
    parameter int NREQ  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*ASIZE-1:0]  req_addr_i,
    output logic [NREQ-1:0]        req_grant_o,
    output logic [ASIZE-1:0]       mem_addr_o,
    output logic                   mem_read_o,
    input  logic                   mem_ready_i,
    input  logic                   mem_word_valid_i,
    input  logic [WSIZE-1:0]       mem_word_i,
    output logic [WSIZE*WORDS-1:0] block_out_o,
    output logic                   block_valid_o,
    input  logic                   block_ack_i,
    output logic                   busy_o
);

    localparam int unsigned BPW  = bytes_per_word(WSIZE);
    localparam int unsigned OFFB = block_offset_bits(WSIZE, WORDS);
    localparam int CW = $clog2(WORDS);
    localparam int LW = $clog2(NREQ);

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [ASIZE-1:0]       base_q, base_d;
    logic [ASIZE-1:0]       mem_addr_q, mem_addr_d;
    logic                   mem_read_q, mem_read_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic [LW-1:0]          last_q, last_d;
    logic [WSIZE*WORDS-1:0] block_q, block_d;
    logic                   block_valid_q, block_valid_d;
    logic                   busy_q, busy_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [ASIZE-1:0] sel_addr;
    logic [ASIZE-1:0] next_off;
    logic [LW-1:0]    win_idx;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        sel_addr = '0;
        win_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) sel_addr = req_addr_i[i*ASIZE +: ASIZE];
            if (grant_q[i]) win_idx = LW'(i);
        end
    end

    // Offset of the word after the current one; wraps modulo 2^ASIZE with the add.
    assign next_off = ASIZE'((int'(count_q) + 1) * int'(BPW));

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        base_d        = base_q;
        mem_addr_d    = mem_addr_q;
        mem_read_d    = mem_read_q;
        grant_d       = grant_q;
        last_d        = last_q;
        block_d       = block_q;
        block_valid_d = block_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    grant_d    = arb_gnt;
                    base_d     = ASIZE'(block_align(64'(sel_addr), OFFB));
                    mem_addr_d = base_d;
                    mem_read_d = 1'b1;
                    count_d    = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready_i) begin
                    mem_read_d = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_word_valid_i) begin
                    block_d[int'(count_q)*WSIZE +: WSIZE] = mem_word_i;
                    if (count_q == CW'(WORDS - 1)) begin
                        block_valid_d = 1'b1;
                        state_d       = ST_DELIVER;
                    end else begin
                        count_d    = count_q + 1'b1;
                        mem_addr_d = base_q + next_off;
                        mem_read_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_DELIVER: begin
                if (block_ack_i) begin
                    block_valid_d = 1'b0;
                    grant_d       = '0;
                    last_d        = win_idx;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            base_q        <= '0;
            mem_addr_q    <= '0;
            mem_read_q    <= 1'b0;
            grant_q       <= '0;
            last_q        <= LW'(NREQ - 1);
            block_q       <= '0;
            block_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            base_q        <= base_d;
            mem_addr_q    <= mem_addr_d;
            mem_read_q    <= mem_read_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            block_q       <= block_d;
            block_valid_q <= block_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign req_grant_o   = grant_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_read_o    = mem_read_q;
    assign block_out_o   = block_q;
    assign block_valid_o = block_valid_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_block_fill_scheduler.sv
// Directed bench for block_fill_scheduler with a one-cycle-latency memory responder.
module tb_block_fill_scheduler;

    localparam int WSIZE = 32;
    localparam int WORDS = 4;
    localparam int ASIZE = 32;
    localparam int NREQ  = 2;
    localparam logic [127:0] BLK = {32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001};

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*ASIZE-1:0]  req_addr = '0;
    logic [NREQ-1:0]        grant;
    logic [ASIZE-1:0]       mem_addr;
    logic                   mem_read;
    logic                   mem_ready = 1'b0;
    logic                   mem_word_valid;
    logic [WSIZE-1:0]       mem_word;
    logic [WSIZE*WORDS-1:0] block_out;
    logic                   block_valid;
    logic                   block_ack = 1'b0;
    logic                   busy;

    logic        resp_wv = 1'b0, spur_wv = 1'b0, pend = 1'b0;
    logic [31:0] resp_data = '0, spur_data = '0, pend_data = '0;
    int total = 0, bad = 0;

    assign mem_word_valid = resp_wv | spur_wv;
    assign mem_word       = spur_wv ? spur_data : resp_data;

    always #5 clk = ~clk;

    block_fill_scheduler #(.WSIZE(WSIZE), .WORDS(WORDS), .ASIZE(ASIZE), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_grant_o(grant), .mem_addr_o(mem_addr), .mem_read_o(mem_read),
        .mem_ready_i(mem_ready), .mem_word_valid_i(mem_word_valid), .mem_word_i(mem_word),
        .block_out_o(block_out), .block_valid_o(block_valid), .block_ack_i(block_ack),
        .busy_o(busy)
    );

    // Memory: a read accepted at an edge returns AAAA0001 + word index one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            pend      = mem_read && mem_ready && rst_n;
            pend_data = 32'hAAAA0001 + {28'd0, mem_addr[3:2]};
            @(posedge clk);
            #1;
            resp_wv   = pend;
            resp_data = pend_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; block_ack = 1'b0; mem_ready = 1'b0; spur_wv = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic ack_block();
        block_ack = 1'b1;
        tick();
        block_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%h exp=0", grant); end
        total++; if ({mem_read, mem_addr} !== 33'd0) begin bad++; $display("FAIL reset_mem got=%b/%h exp=0/0", mem_read, mem_addr); end
        total++; if (block_out !== 128'd0) begin bad++; $display("FAIL reset_block got=%h exp=0", block_out); end
        total++; if ({block_valid, busy} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {block_valid, busy}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] exp_a [4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        logic [31:0] seen [$];
        logic early = 1'b0;
        req_addr = {32'h0, 32'h0000_1234}; req_valid = 2'b01; mem_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) begin
                total++; if ({grant, busy} !== 3'b011) begin bad++; $display("FAIL single_grant got=%b exp=011", {grant, busy}); end
                req_valid = '0;
            end
            if (mem_read && mem_ready) seen.push_back(mem_addr);
            if (c < 9) early |= block_valid;
        end
        total++; if (seen.size() != 4) begin bad++; $display("FAIL single_nreads got=%0d exp=4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            total++; if (seen[i] !== exp_a[i]) begin bad++; $display("FAIL single_addr%0d got=%h exp=%h", i, seen[i], exp_a[i]); end
        end
        total++; if ({early, block_valid} !== 2'b01) begin bad++; $display("FAIL single_latency got=%b exp=01", {early, block_valid}); end
        total++; if (block_out !== BLK) begin bad++; $display("FAIL single_block got=%h exp=%h", block_out, BLK); end
        ack_block();
        total++; if ({grant, block_valid, busy} !== 4'b0000) begin bad++; $display("FAIL single_idle got=%b exp=0000", {grant, block_valid, busy}); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_o [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        int multi = 0;
        int n;
        do_reset();
        req_addr = {32'h0000_3008, 32'h0000_2000}; req_valid = 2'b11; mem_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            tick();
            total++; if (grant !== exp_o[f]) begin bad++; $display("FAIL rr_order%0d got=%b exp=%b", f, grant, exp_o[f]); end
            n = 0;
            while (!block_valid && n < 40) begin
                tick(); n++;
                if ($countones(grant) > 1) multi++;
            end
            total++; if (!block_valid || block_out !== BLK) begin bad++; $display("FAIL rr_block%0d got=%b/%h exp=1/%h", f, block_valid, block_out, BLK); end
            if (f == 3) req_valid = '0;
            ack_block();
            total++; if ({grant, busy} !== 3'b000) begin bad++; $display("FAIL rr_idle%0d got=%b exp=000", f, {grant, busy}); end
        end
        total++; if (multi != 0) begin bad++; $display("FAIL rr_onehot got=%0d exp=0", multi); end
    endtask

    task automatic test_backpressure();
        logic early = 1'b0;
        req_addr = {32'h0, 32'h0000_1234}; req_valid = 2'b01; mem_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            if (c >= 5 && c <= 8) begin
                total++; if ({mem_read, mem_addr} !== {1'b1, 32'h1238}) begin bad++; $display("FAIL bp_hold%0d got=%b/%h exp=1/1238", c, mem_read, mem_addr); end
            end
            if (c >= 5 && c <= 7) mem_ready = 1'b0;
            if (c == 8) mem_ready = 1'b1;
            if (c < 12) early |= block_valid;
        end
        total++; if ({early, block_valid} !== 2'b01) begin bad++; $display("FAIL bp_latency got=%b exp=01", {early, block_valid}); end
        total++; if (block_out !== BLK) begin bad++; $display("FAIL bp_block got=%h exp=%h", block_out, BLK); end
        ack_block();
    endtask

    task automatic test_late_ack();
        req_addr = {32'h0000_5010, 32'h0}; req_valid = 2'b10; mem_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) begin
                total++; if (grant !== 2'b10) begin bad++; $display("FAIL late_grant got=%b exp=10", grant); end
            end
            if (c == 2) req_valid = '0;
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({block_valid, grant} !== 3'b110 || block_out !== BLK) begin
                bad++; $display("FAIL late_hold%0d got=%b/%b/%h exp=1/10/%h", k, block_valid, grant, block_out, BLK);
            end
            tick();
        end
        ack_block();
        total++; if ({grant, block_valid, busy} !== 4'b0000) begin bad++; $display("FAIL late_idle got=%b exp=0000", {grant, block_valid, busy}); end
    endtask

    task automatic test_spurious();
        int n = 0;
        spur_data = 32'hDEADBEEF; spur_wv = 1'b1;
        tick();
        spur_wv = 1'b0;
        total++; if (busy !== 1'b0 || block_out !== BLK) begin bad++; $display("FAIL spur_idle got=%b/%h exp=0/%h", busy, block_out, BLK); end
        req_addr = {32'h0, 32'h0000_0100}; req_valid = 2'b01; mem_ready = 1'b0;
        tick();
        req_valid = '0; spur_wv = 1'b1; block_ack = 1'b1;
        tick();
        block_ack = 1'b0;
        total++; if ({busy, mem_read, mem_addr, block_valid} !== {2'b11, 32'h100, 1'b0}) begin bad++; $display("FAIL spur_issue got=%b/%b/%h/%b exp=1/1/100/0", busy, mem_read, mem_addr, block_valid); end
        total++; if (block_out !== BLK) begin bad++; $display("FAIL spur_issue_blk got=%h exp=%h", block_out, BLK); end
        mem_ready = 1'b1;
        tick();
        spur_wv = 1'b0;
        total++; if (mem_read !== 1'b0 || block_out !== BLK) begin bad++; $display("FAIL spur_accept got=%b/%h exp=0/%h", mem_read, block_out, BLK); end
        while (!block_valid && n < 40) begin tick(); n++; end
        total++; if (!block_valid || block_out !== BLK) begin bad++; $display("FAIL spur_block got=%b/%h exp=1/%h", block_valid, block_out, BLK); end
        ack_block();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        req_addr = {32'h0, 32'h0000_1234}; req_valid = 2'b01; mem_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) req_valid = '0;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({grant, mem_read, mem_addr, block_valid, busy} !== 37'd0 || block_out !== 128'd0) begin
            bad++; $display("FAIL mid_reset got=%b/%b/%h/%b/%b/%h exp=all zero", grant, mem_read, mem_addr, block_valid, busy, block_out);
        end
        tick();
        rst_n = 1'b1;
        spur_data = 32'hAAAA0002; spur_wv = 1'b1;
        tick();
        spur_wv = 1'b0;
        total++; if (busy !== 1'b0 || block_out !== 128'd0) begin bad++; $display("FAIL mid_stale got=%b/%h exp=0/0", busy, block_out); end
        req_addr = {32'h0000_3008, 32'h0000_1234}; req_valid = 2'b11;
        tick();
        req_valid = '0;
        total++; if ({grant, mem_read, mem_addr} !== {2'b01, 1'b1, 32'h1230}) begin bad++; $display("FAIL mid_restart got=%b/%b/%h exp=01/1/1230", grant, mem_read, mem_addr); end
        while (!block_valid && n < 40) begin tick(); n++; end
        total++; if (!block_valid || block_out !== BLK) begin bad++; $display("FAIL mid_block got=%b/%h exp=1/%h", block_valid, block_out, BLK); end
        ack_block();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_late_ack();
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
